iter_mult: RTL and testbench

Parametrised iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits, with per-operation signed/unsigned mode and valid/ready handshakes on both sides. It succeeds the fixed 4x4 combinational multiplier used behind the tile I/O. It trades latency (WIDTH cycles) for area, returns the full product including the top bit, and holds its result under back-pressure. It sits between the input-capture logic and the output drivers of the top-level tile.

---
 rtl/iter_mult.sv | 117 +++++++++++
 tb/tb_iter_mult.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/iter_mult.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// One product bit per clock; valid/ready on both sides; result held until taken.
//
// Ports:
//   clk, rst       clock, async active-high reset
//   in_valid/ready operand handshake (ready only in IDLE)
//   in_a, in_b     multiplicand, multiplier
//   in_signed      1 = two's-complement operands
//   out_valid/ready result handshake
//   out_product    full 2*WIDTH-bit product
//   busy           operation in flight or awaiting pickup
module iter_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_first;
  logic [2*WIDTH-1:0] acc_nx;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nx;
  logic               neg;
  logic               zero_op;
  logic               last;

  // Upper half is the running sum, lower half holds the
  // not-yet-consumed multiplier bits. The sum is WIDTH+1
  // bits so the carry is shifted down instead of lost.
  function automatic logic [2*WIDTH-1:0] step(
    input logic [2*WIDTH-1:0] a,
    input logic [WIDTH-1:0]   m
  );
    logic [WIDTH:0] s;
    s = {1'b0, a[2*WIDTH-1:WIDTH]}
      + {1'b0, (a[0] ? m : {WIDTH{1'b0}})};
    return {s, a[WIDTH-1:1]};
  endfunction

  // |x| as unsigned: -2^(W-1) wraps to 2^(W-1), which is
  // exactly the magnitude wanted.
  always_comb begin
    mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    mag_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
  end

  assign zero_op   = (mag_a == '0) || (mag_b == '0);
  assign acc_first = step({{WIDTH{1'b0}}, mag_b}, mag_a);
  assign acc_nx    = step(acc, mcand);
  assign count_nx  = count + CW'(1);
  assign last      = (count_nx == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = zero_op ? DONE : CALC;
      CALC: if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // The accept edge already performs the first step, so
  // CALC needs only WIDTH-1 further edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand       <= '0;
      acc         <= '0;
      count       <= '0;
      neg         <= 1'b0;
      out_product <= '0;
    end else if (state == IDLE && in_valid) begin
      mcand <= mag_a;
      acc   <= acc_first;
      count <= '0;
      neg   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      if (zero_op) out_product <= '0;
    end else if (state == CALC) begin
      acc   <= acc_nx;
      count <= count_nx;
      if (last) out_product <= neg ? -acc_nx : acc_nx;
    end
  end

endmodule

// File: tb/tb_iter_mult.sv
// Directed bench for iter_mult: 8-bit signed/unsigned, zero, back-pressure,
// reset mid-op; 4-bit exhaustive unsigned sweep and cadence.
module tb_iter_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        in_valid, in_signed, out_ready;
  logic [7:0]  in_a, in_b;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_product;

  logic       in_valid4, in_signed4, out_ready4;
  logic [3:0] in_a4, in_b4;
  logic       in_ready4, out_valid4, busy4;
  logic [7:0] out_product4;

  int checks = 0;
  int errors = 0;

  iter_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .busy(busy)
  );

  iter_mult #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_signed(in_signed4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_product(out_product4), .busy(busy4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got 0x%0h exp 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b,
                        input logic s);
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat counts edges inclusive of the accept edge.
  task automatic wait8(output int lat);
    bit ok;
    ok  = 1'b1;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (in_ready) ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("ready_low_calc", ok, 1);
  endtask

  task automatic op8(input string tag,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic s, input logic [15:0] exp,
                     input int exp_lat);
    int lat;
    start8(a, b, s);
    wait8(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk(tag, out_product, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_hs"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    int lat;
    int t0, t1;
    rst = 1'b1;
    in_valid = 0; in_signed = 0; out_ready = 0; in_a = 0; in_b = 0;
    in_valid4 = 0; in_signed4 = 0; out_ready4 = 1; in_a4 = 0; in_b4 = 0;
    #2;
    chk("rst8_flags", {in_ready, out_valid, busy}, 3'b100);
    chk("rst8_prod", out_product, 0);
    chk("rst4_flags", {in_ready4, out_valid4, busy4}, 3'b100);
    chk("rst4_prod", out_product4, 0);
    @(negedge clk);
    rst = 1'b0;

    op8("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 8);
    op8("s-128x-128", 8'h80, 8'h80, 1'b1, 16'h4000, 8);
    op8("s-3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 8);
    op8("s127x-1", 8'h7F, 8'hFF, 1'b1, 16'hFF81, 8);
    op8("u0x200", 8'h00, 8'hC8, 1'b0, 16'h0000, 1);
    op8("u7x9", 8'h07, 8'h09, 1'b0, 16'h003F, 8);
    op8("s-7x0", 8'hF9, 8'h00, 1'b1, 16'h0000, 1);

    // back-pressure with competing operands on the input
    start8(8'd13, 8'd11, 1'b0);
    wait8(lat);
    chk("bp_lat", lat, 8);
    in_a = 8'd99; in_b = 8'd99; in_signed = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_flags", {out_valid, in_ready, busy}, 3'b101);
      chk("bp_hold_prod", out_product, 16'h008F);
      @(negedge clk);
    end
    chk("bp_prod", out_product, 16'h008F);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_flags", {out_valid, in_ready, busy}, 3'b010);
    chk("bp_idle_prod", out_product, 16'h008F);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("bp_not_taken", {out_valid, in_ready, busy}, 3'b010);

    // reset in the middle of CALC
    start8(8'd200, 8'd3, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_flags", {in_ready, out_valid, busy}, 3'b100);
    chk("mid_rst_prod", out_product, 0);
    @(negedge clk);
    chk("rst_held_flags", {in_ready, out_valid, busy}, 3'b100);
    rst = 1'b0;
    in_a = 8'd12; in_b = 8'd10; in_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait8(lat);
    chk("post_rst_lat", lat, 8);
    chk("post_rst_prod", out_product, 16'h0078);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // WIDTH=4 exhaustive unsigned sweep, out_ready tied high
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [15:0] exp4;
        exp4[15:8] = (a == 0 || b == 0) ? 8'd1 : 8'd4;
        exp4[7:0]  = 8'(a * b);
        @(negedge clk);
        in_a4 = 4'(a); in_b4 = 4'(b); in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 20) begin
          @(negedge clk);
          lat++;
        end
        chk($sformatf("w4_%0dx%0d", a, b),
            {8'(lat), out_product4}, exp4);
      end
    end

    // back-to-back: accept edges W+1 apart (W+2 edges inclusive)
    @(negedge clk);
    in_a4 = 4'd15; in_b4 = 4'd15; in_valid4 = 1'b1;
    t0 = -1; t1 = -1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready4) begin
        if (t0 < 0) t0 = i;
        else if (t1 < 0) t1 = i;
      end
      @(negedge clk);
    end
    in_valid4 = 1'b0;
    chk("w4_cadence", 64'(t1 - t0), 5);
    repeat (8) @(negedge clk);
    chk("w4_drain_busy", busy4, 0);
    chk("w4_15x15", out_product4, 8'hE1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
